// File: rtl/elevator_call_panel.sv
// elevator_call_panel: synchronises and debounces floor buttons, emits request pulses and holds call lamps
module elevator_call_panel #(
  parameter int FLOORS          = 5,
  parameter int POS_W           = 3,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLOORS-1:0] btn_raw,
  input  logic [POS_W-1:0]  floor_pos,
  input  logic              door_open,
  output logic [FLOORS-1:0] floor_req,
  output logic [FLOORS-1:0] call_lamp,
  output logic              pending_any
);
  localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);
  logic [FLOORS-1:0] s1, s2, deb, flip, press, serve;
  logic [7:0] cnt [FLOORS];
  always_comb begin
    flip  = '0;
    serve = '0;
    for (int i = 0; i < FLOORS; i++) begin
      flip[i]  = s2[i] != deb[i] && cnt[i] == LAST;
      serve[i] = door_open && int'(floor_pos) == i;
    end
    press = flip & s2;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1          <= '0;
      s2          <= '0;
      deb         <= '0;
      call_lamp   <= '0;
      floor_req   <= '0;
      pending_any <= 1'b0;
      for (int i = 0; i < FLOORS; i++) cnt[i] <= '0;
    end else begin
      s1          <= btn_raw;
      s2          <= s1;
      deb         <= deb ^ flip;
      call_lamp   <= (call_lamp | press) & ~serve;
      floor_req   <= press & ~call_lamp & ~serve;
      pending_any <= |call_lamp;
      for (int i = 0; i < FLOORS; i++)
        cnt[i] <= (s2[i] == deb[i] || flip[i]) ? 8'd0 : cnt[i] + 8'd1;
    end
  end
endmodule

// File: tb/tb_elevator_call_panel.sv
// tb_elevator_call_panel: randomized bouncing buttons and door traffic checked against a run-length reference model
module tb_elevator_call_panel;
  localparam int F = 5, W = 3, D = 4;
  logic clk = 1'b0, reset, door_open, pending_any;
  logic [F-1:0] btn_raw, floor_req, call_lamp;
  logic [W-1:0] floor_pos;
  int total = 0, bad = 0;
  bit [F-1:0] q1, q2, lvl, lamp, req, tgt;
  bit pend;
  int run [F];
  always #5 clk = ~clk;
  elevator_call_panel #(.FLOORS(F), .POS_W(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .floor_pos(floor_pos),
    .door_open(door_open), .floor_req(floor_req), .call_lamp(call_lamp),
    .pending_any(pending_any)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  // a level is accepted after D consecutive synchronised samples disagree with it
  task automatic model();
    bit [F-1:0] press;
    bit sv;
    press = '0;
    if (reset) begin
      q1 = '0; q2 = '0; lvl = '0; lamp = '0; req = '0; pend = 1'b0;
      for (int i = 0; i < F; i++) run[i] = 0;
      return;
    end
    pend = |lamp;
    for (int i = 0; i < F; i++) begin
      if (q2[i] != lvl[i]) begin
        run[i]++;
        if (run[i] == D) begin
          lvl[i] = q2[i];
          run[i] = 0;
          press[i] = lvl[i];
        end
      end else run[i] = 0;
    end
    for (int i = 0; i < F; i++) begin
      sv = door_open && int'(floor_pos) == i;
      req[i]  = press[i] && !lamp[i] && !sv;
      lamp[i] = sv ? 1'b0 : (lamp[i] | press[i]);
    end
    q2 = q1;
    q1 = btn_raw;
  endtask
  initial begin
    reset = 1'b1; btn_raw = '0; floor_pos = '0; door_open = 1'b0; tgt = '0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      model();
      #1;
      chk("floor_req", 32'(floor_req), 32'(req));
      chk("call_lamp", 32'(call_lamp), 32'(lamp));
      chk("pending_any", 32'(pending_any), 32'(pend));
      @(negedge clk);
      reset = (c < 2) || $urandom_range(399) == 0;
      for (int i = 0; i < F; i++) begin
        if ($urandom_range(59) == 0) tgt[i] = ~tgt[i];
        btn_raw[i] = ($urandom_range(9) == 0) ? ~tgt[i] : tgt[i];
      end
      if ($urandom_range(11) == 0) door_open = ~door_open;
      if ($urandom_range(9) == 0) floor_pos = W'($urandom_range(7));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/elevator_call_panel.md
# elevator_call_panel

Call-button front end for the elevator controller. It synchronises and debounces the raw, asynchronous floor buttons and emits one-cycle request pulses on `floor_req`, which drive the controller's `floor_req` input. It also holds a call lamp per floor and clears that lamp when the controller reports the door open at that floor. It sits directly upstream of `elevator` and consumes that block's `floor_pos` and `door_open` outputs.

## Interface
- `FLOORS`, default 5: number of floors; must match the controller.
- `POS_W`, default 3: width of the floor index.
- `DEBOUNCE_CYCLES`, default 4: number of consecutive cycles a synchronised input must differ from its debounced value before it is accepted. Legal range 1–255.
- `clk`  in  1: the single clock. All logic is on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `btn_raw`  in  FLOORS: raw, asynchronous, bouncing buttons; 1 = pressed.
- `floor_pos`  in  POS_W: current floor index from the controller.
- `door_open`  in  1: door-open indicator from the controller.
- `floor_req`  out  FLOORS: one-cycle request pulses to the controller; registered.
- `call_lamp`  out  FLOORS: latched call lamps; registered.
- `pending_any`  out  1: OR-reduction of `call_lamp`; registered.

## Operation
- Per-floor pipeline, `i` = 0..FLOORS-1: 2-flop synchroniser (`s1[i]`, `s2[i]`) -> debounce counter `cnt[i]` (8 bits) -> debounced level `deb[i]`.
- Debounce rule, evaluated every edge:
  - If `s2[i] == deb[i]`: `cnt[i] <= 0`.
  - Else if `cnt[i] == DEBOUNCE_CYCLES-1`: `deb[i] <= s2[i]`, `cnt[i] <= 0`.
  - Else: `cnt[i] <= cnt[i] + 1`.
  - Any glitch shorter than `DEBOUNCE_CYCLES` consecutive differing samples never changes `deb`.
- An accepted press is the edge on which `deb[i]` goes 0 -> 1. Releases (1 -> 0) only update `deb`; they produce no output.
- Serving condition for floor `i`: `door_open && floor_pos == i`. A `floor_pos` value >= FLOORS matches no floor.
- Per-floor update, evaluated on every edge in this priority order:
  1. Serving condition true: `call_lamp[i] <= 0` and `floor_req[i] <= 0`. An accepted press on this same edge is discarded; the door is already serving this floor.
  2. Otherwise, accepted press with `call_lamp[i] == 0`: `call_lamp[i] <= 1` and `floor_req[i] <= 1` for exactly one cycle.
  3. Otherwise, accepted press with `call_lamp[i] == 1`: lamp stays 1 and `floor_req[i] <= 0`. No duplicate pulse is sent.
  4. Otherwise: `floor_req[i] <= 0`; lamp holds.
- `pending_any` is registered and equals `|call_lamp` one cycle late.
- Simultaneous presses on several floors on the same edge each produce their own pulse on the same cycle.
- Floors are fully independent; no state machine is shared across floors.

## Timing
- Reset: on the first edge with `reset` = 1, all state clears to 0: `s1`, `s2`, `cnt`, `deb`, `call_lamp`, `floor_req`, `pending_any`. Reset overrides every other rule, including mid-debounce and mid-pulse.
- Button held through reset: `deb` restarts at 0, so the held button is accepted as a fresh press after the full latency once reset deasserts.
- Press latency: `btn_raw[i]` is first sampled high at edge E0 (reset already low) and stays high. `floor_req[i]` and `call_lamp[i]` then assert after edge E(DEBOUNCE_CYCLES+1). With the default of 4, that is after E5.
- `floor_req` pulse width is exactly 1 cycle.
- Lamp clear latency: the serving condition is true at edge En; `call_lamp[i]` is 0 after En and `pending_any` is 0 after En+1 (if no other lamps are lit).
- `DEBOUNCE_CYCLES` = 1: `deb` follows `s2` with one edge of delay, giving a press latency of E2.

## Test plan
- Clean press, DEBOUNCE_CYCLES = 4: floor 2 held high from E0 -> `floor_req` = 5'b00100 for the single cycle after E5; `call_lamp[2]` = 1 from then on; `pending_any` = 1 one cycle later.
- Bounce: floor 3 toggles 1,0,1,1,0,1,1,1,1 (one value per cycle) -> exactly one pulse, produced only after the final run of 4 consecutive high synchronised samples; no pulse from the earlier short runs.
- Duplicate press: floor 1 pressed, released, pressed again with its lamp still lit -> first press gives one pulse; the second gives none; `call_lamp[1]` stays 1.
- Service clear: lamp 4 lit, then `door_open` = 1 with `floor_pos` = 4 -> `call_lamp[4]` = 0 the next cycle. A floor-4 press accepted while the door stays open gives no pulse and no lamp.
- Multi-floor: floors 0 and 3 pressed on the same cycle -> one `floor_req` = 5'b01001 pulse. `floor_pos` = 7 with `door_open` = 1 clears nothing.
- Reset mid-debounce: `reset` asserted while `cnt[2]` = 2 with lamp 0 lit -> the next cycle every output is 0. After release, the still-held floor-2 button pulses after edge E5, counted from the first sampling edge after reset deasserts.
